// File: rtl/mod_n_counter_if.sv
// Control/status bundle for mod_n_counter: the master drives the count controls,
// the counter (slave) returns count, terminal-count and run status.
interface mod_n_counter_if #(
  parameter int WIDTH = 5
);
  logic             en;
  logic             dir;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             wrap;
  logic             busy;
  logic             done;

  modport master (
    output en, dir, clr, load, load_val, start,
    input  out, tc, wrap, busy, done
  );

  modport slave (
    input  en, dir, clr, load, load_val, start,
    output out, tc, wrap, busy, done
  );
endinterface

// File: rtl/mod_n_counter.sv
// Modulo-N up/down counter with clear/load, free-running wrap mode (ONESHOT=0)
// or a start/done single-run mode (ONESHOT=1).
module mod_n_counter #(
  parameter int MODULUS = 24,
  parameter int WIDTH   = 5,
  parameter int ONESHOT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  mod_n_counter_if.slave     bus
);

  // MODULUS may equal 2**WIDTH, so the load comparison is done one bit wider.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_W   = (WIDTH + 1)'(MODULUS);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] w_out_next;
  logic             r_wrap;
  logic             w_wrap_next;
  logic             r_done;
  logic             w_done_next;

  logic             w_tc;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_load_sat;

  assign w_tc       = bus.dir ? (r_out == MAX_VAL) : (r_out == '0);
  assign w_step     = bus.dir ? (w_tc ? '0 : r_out + 1'b1)
                              : (w_tc ? MAX_VAL : r_out - 1'b1);
  assign w_load_sat = ({1'b0, bus.load_val} < MOD_W) ? bus.load_val : MAX_VAL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_out   <= '0;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_out   <= w_out_next;
      r_wrap  <= w_wrap_next;
      r_done  <= w_done_next;
    end
  end

  // Priority clr > load > start > step; only one action per cycle.
  always_comb begin
    w_state_next = r_state;
    w_out_next   = r_out;
    w_wrap_next  = 1'b0;
    w_done_next  = 1'b0;
    if (bus.clr) begin
      w_state_next = IDLE;
      w_out_next   = '0;
    end else if (bus.load) begin
      w_out_next = w_load_sat;
    end else if ((ONESHOT != 0) && (r_state == IDLE) && bus.start) begin
      w_state_next = RUN;
      w_out_next   = bus.dir ? '0 : MAX_VAL;
    end else if (ONESHOT == 0) begin
      if (bus.en) begin
        w_out_next  = w_step;
        w_wrap_next = w_tc;
      end
    end else if ((r_state == RUN) && bus.en) begin
      // A run ends on its terminal value instead of wrapping.
      if (w_tc) begin
        w_state_next = IDLE;
        w_done_next  = 1'b1;
      end else begin
        w_out_next = w_step;
      end
    end
  end

  assign bus.out  = r_out;
  assign bus.tc   = w_tc;
  assign bus.wrap = r_wrap;
  assign bus.busy = (ONESHOT != 0) && (r_state == RUN);
  assign bus.done = r_done;

endmodule

// File: tb/tb_mod_n_counter.sv
// Directed bench: a free-running and a one-shot counter share one stimulus stream
// and are checked every cycle against an arithmetic model plus literal spot checks.
module tb_mod_n_counter;

  localparam int MOD = 24;
  localparam int W   = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mod_n_counter_if #(.WIDTH(W)) if0 ();
  mod_n_counter_if #(.WIDTH(W)) if1 ();

  mod_n_counter #(.MODULUS(MOD), .WIDTH(W), .ONESHOT(0)) u_free (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  mod_n_counter #(.MODULUS(MOD), .WIDTH(W), .ONESHOT(1)) u_shot (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    $display("vec %-14s dut=%0d exp=%0d", name, act, exp);
    chk(name, act, exp);
  endtask

  // Reference model: index 0 = free-running, index 1 = one-shot.
  int m_out  [2] = '{0, 0};
  bit m_wrap [2] = '{0, 0};
  bit m_busy [2] = '{0, 0};
  bit m_done [2] = '{0, 0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_out[k] = 0; m_wrap[k] = 0; m_busy[k] = 0; m_done[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int nxt;
        bit at_end;
        nxt    = if0.dir ? (m_out[k] + 1) % MOD : (m_out[k] + MOD - 1) % MOD;
        at_end = if0.dir ? (m_out[k] == MOD - 1) : (m_out[k] == 0);
        m_wrap[k] = 0;
        m_done[k] = 0;
        if (if0.clr) begin
          m_out[k] = 0; m_busy[k] = 0;
        end else if (if0.load) begin
          m_out[k] = (int'(if0.load_val) < MOD) ? int'(if0.load_val) : MOD - 1;
        end else if (k == 1 && !m_busy[k] && if0.start) begin
          m_busy[k] = 1;
          m_out[k]  = if0.dir ? 0 : MOD - 1;
        end else if (k == 0 && if0.en) begin
          m_wrap[k] = at_end;
          m_out[k]  = nxt;
        end else if (k == 1 && m_busy[k] && if0.en) begin
          if (at_end) begin
            m_busy[k] = 0; m_done[k] = 1;
          end else begin
            m_out[k] = nxt;
          end
        end
      end
    end
  end

  function automatic bit m_tc(input int k);
    return if0.dir ? (m_out[k] == MOD - 1) : (m_out[k] == 0);
  endfunction

  always @(negedge clk) begin
    chk("free.out",  if0.out,  m_out[0]);
    chk("free.tc",   if0.tc,   m_tc(0));
    chk("free.wrap", if0.wrap, m_wrap[0]);
    chk("free.busy", if0.busy, 0);
    chk("free.done", if0.done, 0);
    chk("shot.out",  if1.out,  m_out[1]);
    chk("shot.tc",   if1.tc,   m_tc(1));
    chk("shot.wrap", if1.wrap, 0);
    chk("shot.busy", if1.busy, m_busy[1]);
    chk("shot.done", if1.done, m_done[1]);
  end

  task automatic drive(input logic en, input logic dir, input logic clr, input logic load,
                       input logic [W-1:0] lv, input logic start);
    if0.en = en; if0.dir = dir; if0.clr = clr; if0.load = load; if0.load_val = lv; if0.start = start;
    if1.en = en; if1.dir = dir; if1.clr = clr; if1.load = load; if1.load_val = lv; if1.start = start;
  endtask

  // Inputs change 2 time units after a rising edge, well clear of both edges.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    drive(0, 1, 0, 0, '0, 0);
    #1 rst_n = 1'b0;
    #2;
    lit("rst.out0",  if0.out,  0);
    lit("rst.busy1", if1.busy, 0);
    cyc(1);
    rst_n = 1'b1;

    // Free-running count up through one wrap; one-shot idles.
    drive(1, 1, 0, 0, '0, 0);
    cyc(5);
    lit("up.out0_5", if0.out, 5);
    lit("idle.out1", if1.out, 0);
    cyc(18);
    lit("up.out0_23", if0.out, 23);
    lit("up.tc0",     if0.tc,  1);
    lit("up.wrap0_a", if0.wrap, 0);
    cyc(1);
    lit("up.out0_0",  if0.out,  0);
    lit("up.wrap0_b", if0.wrap, 1);
    cyc(1);
    lit("up.out0_1",  if0.out,  1);
    lit("up.wrap0_c", if0.wrap, 0);

    // Count down from 0.
    drive(0, 0, 1, 0, '0, 0);
    cyc(1);
    drive(1, 0, 0, 0, '0, 0);
    cyc(1);
    lit("dn.out0_23", if0.out,  23);
    lit("dn.wrap0",   if0.wrap, 1);
    cyc(1);
    lit("dn.out0_22", if0.out, 22);
    cyc(1);
    lit("dn.out0_21", if0.out, 21);

    // Load saturation and clr-over-load priority.
    drive(0, 1, 0, 1, 5'd30, 0);
    cyc(1);
    lit("ld.sat_out0", if0.out, 23);
    lit("ld.sat_tc0",  if0.tc,  1);
    lit("ld.sat_out1", if1.out, 23);
    drive(0, 1, 1, 1, 5'd7, 0);
    cyc(1);
    lit("ld.clr_out0", if0.out, 0);
    drive(0, 1, 0, 1, 5'd7, 0);
    cyc(1);
    lit("ld.out0_7", if0.out, 7);

    // One-shot run up to 23.
    drive(0, 1, 1, 0, '0, 0);
    cyc(1);
    drive(0, 1, 0, 0, '0, 1);
    cyc(1);
    lit("run.busy1", if1.busy, 1);
    lit("run.out1",  if1.out,  0);
    drive(1, 1, 0, 0, '0, 0);
    cyc(23);
    lit("run.out1_23", if1.out,  23);
    lit("run.done1_a", if1.done, 0);
    cyc(1);
    lit("run.done1_b", if1.done, 1);
    lit("run.busy1_b", if1.busy, 0);
    lit("run.out1_b",  if1.out,  23);
    cyc(1);
    lit("run.done1_c", if1.done, 0);
    lit("run.out1_c",  if1.out,  23);

    // Restart-while-running ignored, then clr aborts.
    drive(0, 1, 0, 0, '0, 1);
    cyc(1);
    drive(1, 1, 0, 0, '0, 0);
    cyc(10);
    lit("abt.out1_10", if1.out, 10);
    drive(0, 1, 0, 0, '0, 1);
    cyc(1);
    lit("abt.ign_out1",  if1.out,  10);
    lit("abt.ign_busy1", if1.busy, 1);
    drive(1, 1, 1, 0, '0, 0);
    cyc(1);
    lit("abt.out1",  if1.out,  0);
    lit("abt.busy1", if1.busy, 0);
    lit("abt.done1", if1.done, 0);
    drive(0, 1, 0, 0, '0, 0);
    cyc(1);
    lit("abt.done1_b", if1.done, 0);

    // Direction flip mid-run: up to 3, then down to 0 and finish.
    drive(0, 1, 0, 0, '0, 1);
    cyc(1);
    drive(1, 1, 0, 0, '0, 0);
    cyc(3);
    lit("flip.out1_3", if1.out, 3);
    drive(1, 0, 0, 0, '0, 0);
    cyc(3);
    lit("flip.out1_0", if1.out,  0);
    lit("flip.busy1",  if1.busy, 1);
    cyc(1);
    lit("flip.done1", if1.done, 1);
    lit("flip.out1",  if1.out,  0);

    // Down-start, load during a run, then finish counting up.
    drive(0, 0, 0, 0, '0, 1);
    cyc(1);
    lit("dstart.out1", if1.out, 23);
    drive(0, 1, 0, 1, 5'd20, 0);
    cyc(1);
    lit("rld.out1",  if1.out,  20);
    lit("rld.busy1", if1.busy, 1);
    drive(1, 1, 0, 0, '0, 0);
    cyc(4);
    lit("rld.done1", if1.done, 1);

    // Asynchronous reset mid-run at out=15.
    drive(0, 1, 0, 0, '0, 1);
    cyc(1);
    drive(1, 1, 0, 0, '0, 0);
    cyc(15);
    lit("ar.out1_15", if1.out, 15);
    drive(0, 1, 0, 0, '0, 0);
    #1 rst_n = 1'b0;
    #1;
    lit("ar.out1",  if1.out,  0);
    lit("ar.busy1", if1.busy, 0);
    lit("ar.out0",  if0.out,  0);
    #2 rst_n = 1'b1;
    cyc(1);
    lit("ar.idle_busy1", if1.busy, 0);
    drive(0, 1, 0, 1, 5'd9, 0);
    cyc(1);
    drive(0, 1, 0, 0, '0, 0);
    cyc(5);
    lit("hold.out0", if0.out, 9);
    lit("hold.out1", if1.out, 9);

    // A few mixed directed steps for the per-cycle model compare.
    drive(1, 0, 0, 0, '0, 0);
    cyc(12);
    drive(1, 1, 0, 0, '0, 1);
    cyc(8);
    cyc(1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
